alu_issue_sched: RTL and testbench
==================================

# alu_issue_sched

Round-robin issue scheduler that shares the single combinational `alu` among NUM_REQ reservation-station requesters in the dynamic pipeline. Each accepted request passes through an issue register that drives the ALU, then a result register that broadcasts on the common data bus (CDB) under a valid/ready handshake. The block sustains one operation per cycle, absorbs CDB backpressure without losing operations, and supports a pipeline flush.

## Interface
- NUM_REQ, 4: number of requesters; 2..8.
- TAG_W, 4: width of the destination tag carried with each operation.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard every in-flight operation; synchronous.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  one-hot grant; an operation transfers when valid and ready are both high.
- req_aluc  in  4*NUM_REQ  ALU opcode; requester i occupies bits [4i+3:4i].
- req_a, req_b  in  32*NUM_REQ  operands; requester i occupies bits [32i+31:32i].
- req_tag  in  TAG_W*NUM_REQ  destination tag.
- alu_a, alu_b  out  32  ALU operands, driven from the issue register.
- alu_aluc  out  4  ALU opcode, driven from the issue register.
- alu_r  in  32  ALU result.
- alu_zero, alu_carry, alu_negative, alu_overflow  in  1 each  ALU flags.
- cdb_valid  out  1  result register holds a result.
- cdb_ready  in  1  CDB accepts the result this cycle.
- cdb_r  out  32  result.
- cdb_tag  out  TAG_W  destination tag of the result.
- cdb_zero, cdb_carry, cdb_negative, cdb_overflow  out  1 each  captured flags.
- busy  out  1  e_valid | w_valid.

## Operation
- The block has two pipeline stages:
  - E (issue register): e_valid, aluc, a, b, tag.
  - W (result register): w_valid, r, four flags, tag.
- w_free = !w_valid | cdb_ready.
- e_free = !e_valid | w_free.
- **Arbitration:** among requesters with req_valid=1, grant the first one found searching upward from rr_ptr, wrapping mod NUM_REQ.
  - req_ready[g] = e_free & !flush & !rst; every other ready bit is 0.
  - With no valid requester, req_ready is all zero.
  - req_ready depends combinationally on req_valid, rr_ptr, e_valid, w_valid and cdb_ready.
- **Pointer update:** on a transfer from requester g, rr_ptr <= (g+1) mod NUM_REQ. Otherwise rr_ptr holds.
- **E load:** on a transfer, E loads aluc/a/b/tag from requester g and e_valid <= 1. If E is not loaded but E advances to W, e_valid <= 0.
- **ALU drive:** alu_a, alu_b and alu_aluc are always driven from the E register, including when E is empty; the ALU evaluates combinationally in the same cycle.
- **W load:** when e_valid & w_free, W captures alu_r, the flags and E.tag, and w_valid <= 1. Otherwise, if cdb_ready & w_valid, w_valid <= 0.
- **Flags:** passed through unmodified. The scheduler does not interpret aluc.
- **Flush:** e_valid <= 0 and w_valid <= 0. No transfer occurs in that cycle, and rr_ptr holds. Data registers keep their contents.
- **Reset:**
  - All valid bits, rr_ptr, the E and W data, and the flags are cleared to 0.
  - Therefore cdb_* = 0, alu_* = 0, busy = 0 and req_ready = 0 while rst is high.
  - Reset overrides flush and any handshake in the same cycle.

## Timing
- Latency: a transfer in cycle N gives cdb_valid=1 in cycle N+2, provided W is free at N+1.
- Throughput: one operation per cycle while cdb_ready=1.
- **Backpressure:**
  - While cdb_valid=1 and cdb_ready=0, W and all cdb_* outputs are held stable.
  - E holds one further operation, and req_ready drops only once both E and W are full.
  - At most 2 operations are in flight.
- **Simultaneous events:**
  - cdb_ready together with a full E moves E into W in the same edge that W drains.
  - A new request may load E in that same edge.
- flush has priority over all handshakes. A result presented with cdb_valid=1 in the flush cycle is not counted as delivered, and the CDB must ignore it.

## Test plan
- **Single op:** requester 2 issues aluc=0000, a=5, b=7, tag=3 at cycle N; cdb_ready=1 → cycle N+2: cdb_valid=1, cdb_r=12, cdb_tag=3, cdb_zero=0; busy falls at N+3.
- **Contention:** all 4 requesters hold valid continuously after reset → grants in order 0,1,2,3,0; each req_ready is one-hot; 5 results in 5 consecutive cycles starting at cycle 2.
- **Backpressure:** cdb_ready=0 from the cycle the first result appears → that result and its tag stay stable, req_ready goes all zero after exactly 2 accepted ops; raising cdb_ready delivers both in order on consecutive cycles with no loss or duplication.
- **Flush:** two ops in flight, flush=1 with req_valid[1]=1 → req_ready=0 that cycle; next cycle cdb_valid=0 and busy=0; rr_ptr unchanged, so the next grant goes to the same requester.
- **Reset mid-operation:** E and W full, cdb_ready=0, rst=1 for one cycle → after the edge every output is 0 and rr_ptr=0; the first request afterwards goes to the lowest-index valid requester.
- **Signed subtract with overflow:** aluc=0011, a=0x80000000, b=1 → cdb_r=0x7FFFFFFF, cdb_overflow=1, cdb_negative=0.

Source files
------------

// File: rtl/alu_issue_sched.sv
// Round-robin issue scheduler feeding one shared combinational ALU.
// Two stages: E (issue register driving the ALU) and W (result register on the CDB).
module alu_issue_sched #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [4*NUM_REQ-1:0]     req_aluc,
  input  logic [32*NUM_REQ-1:0]    req_a,
  input  logic [32*NUM_REQ-1:0]    req_b,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [3:0]               alu_aluc,
  input  logic [31:0]              alu_r,
  input  logic                     alu_zero,
  input  logic                     alu_carry,
  input  logic                     alu_negative,
  input  logic                     alu_overflow,
  output logic                     cdb_valid,
  input  logic                     cdb_ready,
  output logic [31:0]              cdb_r,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic                     cdb_zero,
  output logic                     cdb_carry,
  output logic                     cdb_negative,
  output logic                     cdb_overflow,
  output logic                     busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             e_valid_q, e_valid_d;
  logic [3:0]       e_aluc_q, e_aluc_d;
  logic [31:0]      e_a_q, e_a_d;
  logic [31:0]      e_b_q, e_b_d;
  logic [TAG_W-1:0] e_tag_q, e_tag_d;
  logic             w_valid_q, w_valid_d;
  logic [31:0]      w_r_q, w_r_d;
  logic [3:0]       w_flags_q, w_flags_d;
  logic [TAG_W-1:0] w_tag_q, w_tag_d;

  logic             w_free_s;
  logic             e_free_s;
  logic             grant_found_s;
  logic [PTR_W-1:0] grant_idx_s;
  logic             xfer_s;
  logic [3:0]       sel_aluc_s;
  logic [31:0]      sel_a_s;
  logic [31:0]      sel_b_s;
  logic [TAG_W-1:0] sel_tag_s;

  // Requester index base+off, wrapped modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
    return sum[PTR_W-1:0];
  endfunction

  // Round-robin search upward from rr_ptr for the first valid requester.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found_s && req_valid[wrap_add(rr_ptr_q, k)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = wrap_add(rr_ptr_q, k);
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Stage availability, transfer qualification and granted operand select.
  always_comb begin
    w_free_s   = !w_valid_q | cdb_ready;
    e_free_s   = !e_valid_q | w_free_s;
    xfer_s     = grant_found_s & e_free_s & !flush & !rst;
    sel_aluc_s = req_aluc[4*int'(grant_idx_s) +: 4];
    sel_a_s    = req_a[32*int'(grant_idx_s) +: 32];
    sel_b_s    = req_b[32*int'(grant_idx_s) +: 32];
    sel_tag_s  = req_tag[TAG_W*int'(grant_idx_s) +: TAG_W];
  end

  // One-hot grant, only when the transfer actually happens.
  always_comb begin
    req_ready = '0;
    if (xfer_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state for pointer, E and W; flush kills valids but keeps data.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    e_valid_d = e_valid_q;
    e_aluc_d  = e_aluc_q;
    e_a_d     = e_a_q;
    e_b_d     = e_b_q;
    e_tag_d   = e_tag_q;
    w_valid_d = w_valid_q;
    w_r_d     = w_r_q;
    w_flags_d = w_flags_q;
    w_tag_d   = w_tag_q;
    if (flush) begin
      e_valid_d = 1'b0;
      w_valid_d = 1'b0;
    end else begin
      if (xfer_s) begin
        e_valid_d = 1'b1;
        e_aluc_d  = sel_aluc_s;
        e_a_d     = sel_a_s;
        e_b_d     = sel_b_s;
        e_tag_d   = sel_tag_s;
        rr_ptr_d  = wrap_add(grant_idx_s, 1);
      end else if (e_valid_q & w_free_s) begin
        e_valid_d = 1'b0;
      end else begin
        e_valid_d = e_valid_q;
      end
      // E moves into W in the same edge that W drains.
      if (e_valid_q & w_free_s) begin
        w_valid_d = 1'b1;
        w_r_d     = alu_r;
        w_flags_d = {alu_zero, alu_carry, alu_negative, alu_overflow};
        w_tag_d   = e_tag_q;
      end else if (cdb_ready & w_valid_q) begin
        w_valid_d = 1'b0;
      end else begin
        w_valid_d = w_valid_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      e_valid_q <= 1'b0;
      e_aluc_q  <= 4'h0;
      e_a_q     <= 32'h0;
      e_b_q     <= 32'h0;
      e_tag_q   <= '0;
      w_valid_q <= 1'b0;
      w_r_q     <= 32'h0;
      w_flags_q <= 4'h0;
      w_tag_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      e_valid_q <= e_valid_d;
      e_aluc_q  <= e_aluc_d;
      e_a_q     <= e_a_d;
      e_b_q     <= e_b_d;
      e_tag_q   <= e_tag_d;
      w_valid_q <= w_valid_d;
      w_r_q     <= w_r_d;
      w_flags_q <= w_flags_d;
      w_tag_q   <= w_tag_d;
    end
  end

  assign alu_a        = e_a_q;
  assign alu_b        = e_b_q;
  assign alu_aluc     = e_aluc_q;
  assign cdb_valid    = w_valid_q;
  assign cdb_r        = w_r_q;
  assign cdb_tag      = w_tag_q;
  assign cdb_zero     = w_flags_q[3];
  assign cdb_carry    = w_flags_q[2];
  assign cdb_negative = w_flags_q[1];
  assign cdb_overflow = w_flags_q[0];
  assign busy         = e_valid_q | w_valid_q;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Self-checking bench for alu_issue_sched: directed scenarios plus a randomized
// run checked against a queue-level model of in-flight operations.
module tb_alu_issue_sched;

  localparam int N  = 4;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic [N-1:0]    req_valid, req_ready;
  logic [4*N-1:0]  req_aluc;
  logic [32*N-1:0] req_a, req_b;
  logic [TW*N-1:0] req_tag;
  logic [31:0]     alu_a, alu_b, alu_r;
  logic [3:0]      alu_aluc;
  logic            alu_zero, alu_carry, alu_negative, alu_overflow;
  logic            cdb_valid, cdb_ready;
  logic [31:0]     cdb_r;
  logic [TW-1:0]   cdb_tag;
  logic            cdb_zero, cdb_carry, cdb_negative, cdb_overflow;
  logic            busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]   r;
    logic [3:0]    f;
    logic [TW-1:0] tag;
  } res_t;

  alu_issue_sched #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluc(req_aluc), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_r(cdb_r), .cdb_tag(cdb_tag),
    .cdb_zero(cdb_zero), .cdb_carry(cdb_carry), .cdb_negative(cdb_negative),
    .cdb_overflow(cdb_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {r, zero, carry, negative, overflow}.
  function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] wide;
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0000: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0];
        c = wide[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0011: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0001: r = a & b;
      4'b0010: r = a | b;
      4'b0100: r = a ^ b;
      default: r = a ^ ~b;
    endcase
    return {r, (r == 32'h0), c, r[31], v};
  endfunction

  always_comb {alu_r, alu_zero, alu_carry, alu_negative, alu_overflow} = alu_f(alu_aluc, alu_a, alu_b);

  function automatic res_t expect_for(input int i);
    res_t e;
    logic [35:0] o;
    o = alu_f(req_aluc[4*i +: 4], req_a[32*i +: 32], req_b[32*i +: 32]);
    e.r = o[35:4];
    e.f = o[3:0];
    e.tag = req_tag[TW*i +: TW];
    return e;
  endfunction

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
    req_aluc[4*i +: 4]   = op;
    req_a[32*i +: 32]    = a;
    req_b[32*i +: 32]    = b;
    req_tag[TW*i +: TW]  = t;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    cdb_ready = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    cdb_ready = 1'b1;
    req_valid = 4'hF;
    cyc();
    settle();
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if ({cdb_valid, busy} !== 2'b00) begin errors++; $display("FAIL reset_valid_busy: got %b expected 00", {cdb_valid, busy}); end
    checks++; if ({alu_a, alu_b, alu_aluc} !== 68'h0) begin errors++; $display("FAIL reset_alu: got a=%h b=%h op=%h expected 0", alu_a, alu_b, alu_aluc); end
    checks++; if ({cdb_r, cdb_tag, cdb_zero, cdb_carry, cdb_negative, cdb_overflow} !== 40'h0) begin
      errors++; $display("FAIL reset_cdb: got r=%h tag=%h expected 0", cdb_r, cdb_tag);
    end
    rst = 1'b0;
    req_valid = '0;
    cyc();
  endtask

  task automatic test_single_op();
    set_req(2, 4'b0000, 32'd5, 32'd7, 4'd3);
    req_valid = 4'b0100;
    cdb_ready = 1'b1;
    settle();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
    cyc();
    req_valid = '0;
    settle();
    checks++; if ({cdb_valid, busy} !== 2'b01) begin errors++; $display("FAIL single_n1: got valid,busy=%b expected 01", {cdb_valid, busy}); end
    checks++; if ({alu_a, alu_b, alu_aluc} !== {32'd5, 32'd7, 4'd0}) begin errors++; $display("FAIL single_alu_drive: got a=%0d b=%0d expected 5 7", alu_a, alu_b); end
    cyc();
    settle();
    checks++; if ({cdb_valid, cdb_r, cdb_tag, cdb_zero} !== {1'b1, 32'd12, 4'd3, 1'b0}) begin
      errors++; $display("FAIL single_result: got v=%b r=%0d tag=%0d z=%b expected 1 12 3 0", cdb_valid, cdb_r, cdb_tag, cdb_zero);
    end
    cyc();
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
    cyc();
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_oh;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 4'b0000, 32'(i * 10 + 1), 32'(i), 4'(8 + i));
    req_valid = 4'hF;
    cdb_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) req_valid = '0;
      settle();
      if (c < 5) begin
        exp_oh = 4'b0001 << (c % N);
        checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL contention_grant%0d: got %b expected %b", c, req_ready, exp_oh); end
      end
      if (c >= 2) begin
        checks++; if ({cdb_valid, cdb_tag} !== {1'b1, 4'(8 + ((c - 2) % N))}) begin
          errors++; $display("FAIL contention_result%0d: got v=%b tag=%0d expected 1 %0d", c, cdb_valid, cdb_tag, 8 + ((c - 2) % N));
        end
      end
      cyc();
    end
  endtask

  task automatic test_back_pressure();
    int accepted;
    accepted = 0;
    do_reset();
    cdb_ready = 1'b1;
    set_req(0, 4'b0000, 32'd100, 32'd1, 4'd1);
    req_valid = 4'b0001;
    settle(); accepted += int'(req_ready[0]); cyc();
    set_req(0, 4'b0000, 32'd200, 32'd2, 4'd2);
    settle(); accepted += int'(req_ready[0]); cyc();
    set_req(0, 4'b0000, 32'd300, 32'd3, 4'd3);
    cdb_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      settle();
      accepted += int'(req_ready[0]);
      checks++; if ({cdb_valid, cdb_r, cdb_tag} !== {1'b1, 32'd101, 4'd1}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b r=%0d tag=%0d expected 1 101 1", h, cdb_valid, cdb_r, cdb_tag);
      end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d: got %b expected 0000", h, req_ready); end
      cyc();
    end
    checks++; if (accepted !== 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", accepted); end
    req_valid = '0;
    cdb_ready = 1'b1;
    settle();
    checks++; if ({cdb_valid, cdb_r, cdb_tag} !== {1'b1, 32'd101, 4'd1}) begin errors++; $display("FAIL bp_first: got v=%b r=%0d tag=%0d expected 1 101 1", cdb_valid, cdb_r, cdb_tag); end
    cyc();
    settle();
    checks++; if ({cdb_valid, cdb_r, cdb_tag} !== {1'b1, 32'd202, 4'd2}) begin errors++; $display("FAIL bp_second: got v=%b r=%0d tag=%0d expected 1 202 2", cdb_valid, cdb_r, cdb_tag); end
    cyc();
    settle();
    checks++; if ({cdb_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_empty: got valid,busy=%b expected 00", {cdb_valid, busy}); end
    cyc();
  endtask

  task automatic test_flush();
    do_reset();
    cdb_ready = 1'b1;
    set_req(0, 4'b0000, 32'd11, 32'd1, 4'd5);
    req_valid = 4'b0001;
    settle();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_setup0: got %b expected 0001", req_ready); end
    cyc();
    set_req(0, 4'b0000, 32'd22, 32'd2, 4'd6);
    settle();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_setup1: got %b expected 0001", req_ready); end
    cyc();
    flush = 1'b1;
    set_req(1, 4'b0000, 32'd33, 32'd3, 4'd7);
    req_valid = 4'b0011;
    settle();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready: got %b expected 0000", req_ready); end
    cyc();
    flush = 1'b0;
    settle();
    checks++; if ({cdb_valid, busy} !== 2'b00) begin errors++; $display("FAIL flush_cleared: got valid,busy=%b expected 00", {cdb_valid, busy}); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL flush_ptr_hold: got %b expected 0010", req_ready); end
    cyc();
    req_valid = '0;
    settle();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_no_stale: got %b expected 0", cdb_valid); end
    cyc();
    settle();
    checks++; if ({cdb_valid, cdb_r, cdb_tag} !== {1'b1, 32'd36, 4'd7}) begin errors++; $display("FAIL flush_after: got v=%b r=%0d tag=%0d expected 1 36 7", cdb_valid, cdb_r, cdb_tag); end
    cyc();
  endtask

  task automatic test_reset_mid();
    set_req(2, 4'b0000, 32'd44, 32'd4, 4'd9);
    req_valid = 4'b0100;
    cdb_ready = 1'b0;
    settle();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmid_grant0: got %b expected 0100", req_ready); end
    cyc();
    settle();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmid_grant1: got %b expected 0100", req_ready); end
    cyc();
    req_valid = '0;
    settle();
    checks++; if ({cdb_valid, busy} !== 2'b11) begin errors++; $display("FAIL rmid_full: got valid,busy=%b expected 11", {cdb_valid, busy}); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cdb_ready = 1'b1;
    set_req(3, 4'b0000, 32'd50, 32'd5, 4'd12);
    set_req(2, 4'b0000, 32'd60, 32'd6, 4'd13);
    req_valid = 4'b1100;
    settle();
    checks++; if ({cdb_valid, busy, cdb_r, cdb_tag, cdb_zero, cdb_carry, cdb_negative, cdb_overflow} !== 42'h0) begin
      errors++; $display("FAIL rmid_cdb_zero: got v=%b busy=%b r=%h tag=%h expected 0", cdb_valid, busy, cdb_r, cdb_tag);
    end
    checks++; if ({alu_a, alu_b, alu_aluc} !== 68'h0) begin errors++; $display("FAIL rmid_alu_zero: got a=%h b=%h op=%h expected 0", alu_a, alu_b, alu_aluc); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmid_ptr_zero: got %b expected 0100", req_ready); end
    cyc();
    req_valid = '0;
    settle();
    cyc();
    settle();
    checks++; if ({cdb_valid, cdb_r, cdb_tag} !== {1'b1, 32'd66, 4'd13}) begin errors++; $display("FAIL rmid_after: got v=%b r=%0d tag=%0d expected 1 66 13", cdb_valid, cdb_r, cdb_tag); end
    cyc();
  endtask

  task automatic test_sub_overflow();
    do_reset();
    set_req(0, 4'b0011, 32'h8000_0000, 32'h1, 4'hA);
    req_valid = 4'b0001;
    cdb_ready = 1'b1;
    settle();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sub_grant: got %b expected 0001", req_ready); end
    cyc();
    req_valid = '0;
    settle();
    cyc();
    settle();
    checks++; if ({cdb_valid, cdb_r, cdb_tag} !== {1'b1, 32'h7FFF_FFFF, 4'hA}) begin
      errors++; $display("FAIL sub_result: got v=%b r=%h tag=%h expected 1 7fffffff a", cdb_valid, cdb_r, cdb_tag);
    end
    checks++; if ({cdb_overflow, cdb_negative} !== 2'b10) begin errors++; $display("FAIL sub_flags: got ovf,neg=%b expected 10", {cdb_overflow, cdb_negative}); end
    cyc();
  endtask

  task automatic test_random();
    res_t q[$];
    res_t got, exp_r;
    int ptr, g;
    logic [N-1:0] exp_ready;
    logic hold_pend;
    logic [31:0] held_r;
    logic [TW-1:0] held_tag;
    do_reset();
    ptr = 0;
    hold_pend = 1'b0;
    held_r = 32'h0;
    held_tag = '0;
    for (int t = 0; t < 400; t++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) set_req(i, 4'($urandom_range(0, 5)), $urandom, 32'($urandom_range(0, 3)), 4'($urandom));
      cdb_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      settle();
      exp_ready = '0;
      g = -1;
      if (!flush && (q.size() < 2 || cdb_ready)) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
        end
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready t=%0d: got %b expected %b", t, req_ready, exp_ready); end
      if (hold_pend) begin
        checks++; if ({cdb_valid, cdb_r, cdb_tag} !== {1'b1, held_r, held_tag}) begin
          errors++; $display("FAIL rand_hold t=%0d: got v=%b r=%h tag=%h expected 1 %h %h", t, cdb_valid, cdb_r, cdb_tag, held_r, held_tag);
        end
      end
      hold_pend = cdb_valid && !cdb_ready && !flush;
      held_r = cdb_r;
      held_tag = cdb_tag;
      if (flush) begin
        q.delete();
      end else begin
        if (cdb_valid && cdb_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++; $display("FAIL rand_spurious t=%0d: got result tag=%h expected none", t, cdb_tag);
          end else begin
            exp_r = q.pop_front();
            got.r = cdb_r; got.f = {cdb_zero, cdb_carry, cdb_negative, cdb_overflow}; got.tag = cdb_tag;
            if (got !== exp_r) begin
              errors++; $display("FAIL rand_data t=%0d: got r=%h f=%b tag=%h expected r=%h f=%b tag=%h", t, got.r, got.f, got.tag, exp_r.r, exp_r.f, exp_r.tag);
            end
          end
        end
        if (g >= 0) begin
          q.push_back(expect_for(g));
          ptr = (g + 1) % N;
        end
      end
      cyc();
    end
    req_valid = '0;
    flush = 1'b0;
    cdb_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      settle();
      if (cdb_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL drain_spurious: got result tag=%h expected none", cdb_tag);
        end else begin
          exp_r = q.pop_front();
          if ({cdb_r, cdb_tag} !== {exp_r.r, exp_r.tag}) begin
            errors++; $display("FAIL drain_data: got r=%h tag=%h expected r=%h tag=%h", cdb_r, cdb_tag, exp_r.r, exp_r.tag);
          end
        end
      end
      cyc();
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL drain_lost: got %0d undelivered expected 0", q.size()); end
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy: got %b expected 0", busy); end
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    cdb_ready = 1'b1;
    req_valid = '0;
    req_aluc = '0;
    req_a = '0;
    req_b = '0;
    req_tag = '0;
    test_reset();
    test_single_op();
    test_contention();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    test_sub_overflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
